// File: rtl/spart_tx_if.sv
// Processor-side SPART bus as seen by the transmit half.
// The driver owns the access strobes and data, and tbr flows back to it.
interface spart_tx_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] data_in;
  logic       tbr;

  modport master (
    output iocs,
    output iorw,
    output ioaddr,
    output data_in,
    input  tbr
  );

  modport slave (
    input  iocs,
    input  iorw,
    input  ioaddr,
    input  data_in,
    output tbr
  );
endinterface

// File: rtl/spart_tx.sv
// SPART transmitter: programmable baud divisor, a one-byte holding register,
// and an 8N1 serialiser that sends contiguous frames when the next byte is already waiting.
module spart_tx #(
  parameter logic [15:0] DIV_RESET = 16'h0412,
  parameter int unsigned DIV_MIN   = 2
) (
  input  logic             clk,
  input  logic             rst,
  spart_tx_if.slave        bus,
  output logic             txd,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [15:0] DIV_FLOOR = 16'(DIV_MIN);

  state_t      r_state;
  logic [15:0] r_div;
  logic [15:0] r_bitcnt;
  logic [7:0]  r_hold;
  logic        r_hold_valid;
  logic        r_tbr;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_idx;
  logic        r_txd;

  logic        w_wr;
  logic        w_wr_data;
  logic        w_wr_div_lo;
  logic        w_wr_div_hi;
  logic        w_accept;
  logic [15:0] w_d;
  logic [15:0] w_reload;
  logic        w_bit_end;

  // Handshake: a TX data write (iocs=1, iorw=0, ioaddr=00) is taken only on an
  // edge where tbr=1; a write seen while tbr=0 is dropped and leaves the holding
  // register untouched. tbr returns high on the edge the byte moves to the shifter.
  assign w_wr        = bus.iocs & ~bus.iorw;
  assign w_wr_data   = w_wr & (bus.ioaddr == 2'b00);
  assign w_wr_div_lo = w_wr & (bus.ioaddr == 2'b10);
  assign w_wr_div_hi = w_wr & (bus.ioaddr == 2'b11);
  assign w_accept    = w_wr_data & r_tbr;

  // The counter is only ever loaded at a bit boundary, so a divisor write
  // never stretches or shortens the bit already in flight.
  assign w_d       = (r_div < DIV_FLOOR) ? DIV_FLOOR : r_div;
  assign w_reload  = w_d - 16'd1;
  assign w_bit_end = (r_bitcnt == 16'd0);

  assign txd         = r_txd;
  assign bus.tbr     = r_tbr;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= DIV_RESET;
    end else begin
      if (w_wr_div_lo) r_div[7:0]  <= bus.data_in;
      if (w_wr_div_hi) r_div[15:8] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_bitcnt     <= 16'd0;
      r_hold       <= 8'd0;
      r_hold_valid <= 1'b0;
      r_tbr        <= 1'b1;
      r_shift      <= 8'd0;
      r_bit_idx    <= 3'd0;
      r_txd        <= 1'b1;
    end else begin
      // Accept and transfer are mutually exclusive: accept needs an empty
      // holding register, transfer needs a full one.
      if (w_accept) begin
        r_hold       <= bus.data_in;
        r_hold_valid <= 1'b1;
        r_tbr        <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_txd <= 1'b1;
          if (r_hold_valid) begin
            r_shift      <= r_hold;
            r_hold_valid <= 1'b0;
            r_tbr        <= 1'b1;
            r_bitcnt     <= w_reload;
            r_txd        <= 1'b0;
            r_state      <= START;
          end
        end

        START: begin
          if (w_bit_end) begin
            r_bit_idx <= 3'd0;
            r_bitcnt  <= w_reload;
            r_txd     <= r_shift[0];
            r_state   <= DATA;
          end else begin
            r_bitcnt <= r_bitcnt - 16'd1;
          end
        end

        DATA: begin
          if (w_bit_end) begin
            r_bitcnt <= w_reload;
            r_shift  <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_txd     <= r_shift[1];
            end
          end else begin
            r_bitcnt <= r_bitcnt - 16'd1;
          end
        end

        STOP: begin
          if (w_bit_end) begin
            // A waiting byte goes straight into a new start bit, no idle gap.
            if (r_hold_valid) begin
              r_shift      <= r_hold;
              r_hold_valid <= 1'b0;
              r_tbr        <= 1'b1;
              r_bitcnt     <= w_reload;
              r_txd        <= 1'b0;
              r_state      <= START;
            end else begin
              r_bitcnt <= 16'd0;
              r_txd    <= 1'b1;
              r_state  <= IDLE;
            end
          end else begin
            r_bitcnt <= r_bitcnt - 16'd1;
          end
        end

        default: begin
          r_txd   <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  a_tbr_tracks_hold: assert property (@(posedge clk) disable iff (!rst)
    r_tbr == ~r_hold_valid);

endmodule

// File: doc/spart_tx.md
# spart_tx

Transmit half of the SPART. It sits directly downstream of the processor-side driver on the SPART bus (`iocs`, `iorw`, `ioaddr`, `databus`). It holds the 16-bit baud divisor that the driver writes after reset, and double-buffers one transmit byte. It serialises each byte onto `txd` as an 8N1 frame. `tbr` reports to the driver when a new byte may be written.

## Interface
Parameters:
- `DIV_RESET`, default 16'h0412: divisor value after reset (1042 clk per bit, 4800 baud).
- `DIV_MIN`, default 2: effective divisor floor; smaller programmed values are clamped to this.

Ports:
- `clk`, input, 1: clock, rising-edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `iocs`, input, 1: chip select; bus access valid only when high.
- `iorw`, input, 1: 1 = read, 0 = write. This block acts only on writes.
- `ioaddr`, input, 2: 00 = TX data, 01 = status/RX (ignored here), 10 = divisor low byte, 11 = divisor high byte.
- `data_in`, input, 8: write data, taken from `databus` by the bus interface. Tristating is handled outside this block.
- `tbr`, output, 1: transmit buffer ready; high when the holding register is empty.
- `txd`, output, 1: serial output, registered, idle high.

## Operation
- Write strobe `wr` = `iocs & ~iorw`, sampled on the rising edge of `clk`.
- Divisor writes:
  - addr 10 loads `div[7:0]`; addr 11 loads `div[15:8]`.
  - Both are accepted at any time.
  - Effective bit period `D = max(div, DIN_MIN)` clocks.
  - A new value takes effect at the next bit-counter reload, which is the next bit boundary; the bit in progress keeps its length.
- TX data write (addr 00):
  - Accepted only when `tbr=1`. The byte goes into the holding register and `hold_valid` is set.
  - A write while `tbr=0` is silently dropped, and holding contents are unchanged.
- `tbr = ~hold_valid`, registered.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: `txd=1`. If `hold_valid`, then on the next edge: shifter <= hold, `hold_valid` cleared, state <= START, `bitcnt` <= D-1.
  - START: `txd=0` for D cycles, then go to DATA with `bit_idx=0`.
  - DATA: `txd = shifter[0]`, LSB first. At each bit end the shifter shifts right and `bit_idx` increments. After bit 7 completes, go to STOP.
  - STOP: `txd=1` for D cycles. At the end, if `hold_valid`, transfer directly to START (no idle gap); otherwise go to IDLE.
- Bit counter:
  - 16-bit down-counter, reloaded with D-1 at each state entry and bit boundary.
  - Bit end occurs when the counter is 0.
- Frame length is exactly 10*D clocks. Back-to-back frames are contiguous.
- Reads and addr 01 accesses have no effect on this block.

## Timing
- Reset values:
  - `txd=1`, `tbr=1`, state=IDLE, `hold_valid=0`, `div=DIV_RESET`.
  - Shifter and counters are 0.
- Reset asserted mid-frame: `txd` returns high asynchronously, and any pending byte is discarded.
- Write at edge N (in IDLE):
  - `tbr` falls after edge N.
  - Transfer to the shifter happens at edge N+1, so `tbr` rises and `txd` falls after edge N+1.
- A write at the same edge as a transfer is dropped, because `tbr` is still 0 at that edge.
- Write during a frame: `tbr` stays low until the transfer at the STOP end edge. The next start bit begins on the cycle right after the last stop cycle.
- Divisor register write latency is 1 edge. There is no effect on the current bit.
- `div` of 0 or 1 is clamped, giving 2-clock bits.

## Test plan
- Reset with `txd` low mid-frame -> `txd=1`, `tbr=1` immediately; `div=0x0412`; 10 idle clocks later `txd` is still 1.
- Program div=0x0008, write 0xA5 -> one cycle later `txd` = 0 for 8 clk, then bits 1,0,1,0,0,1,0,1 at 8 clk each, then 1 for 8 clk. Frame is exactly 80 clk. `tbr` is low for exactly 1 clk.
- div=4, write 0x3C, then write 0xC3 while `tbr=0` during the same frame -> `tbr` stays low until the first STOP ends. The second frame's start bit follows with no gap. Total 80 clk of contiguous frames.
- div=4, with a byte pending, a third write 0xFF while `tbr=0` -> dropped; only 0x3C and 0xC3 appear on `txd`.
- Mid-DATA, write div high/low to 0x0006 from 4 -> the current bit stays 4 clk and later bits are 6 clk.
- div=0x0000, write 0x01 -> 2-clock bits, 20-clock frame. Then assert reset mid-frame -> `txd=1` and `tbr=1`, with no residual frame after release.
